shop_db_v: RTL
==============

SHOP_DB_V -- requirements
Module: shop_db_v

Interface
REQ-001 SHALL have parameter MAX_USERS, default 5, the number of user slots including admin (slot 0), range 2..15.
REQ-002 SHALL have parameter MAX_ITEMS, default 8, the number of stock table entries, range 1..16.
REQ-003 SHALL have parameter QTY_BITS, default 8, the width of each stock count and of i_qty.
REQ-004 SHALL have parameter I_A_NUM_ASCII_CHARS, default 7, the command width in characters; it must fit the longest command key.
REQ-005 SHALL have parameter O_A_NUM_ASCII_CHARS, default 9, the response width in characters.
REQ-006 SHALL have parameter I_U_NUM_BITS, default 4, and parameter I_ITEM_NUM_BITS, default 4.
REQ-007 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-008 i_reset_n  input  1  reset, asynchronous and active-low.
REQ-009 i_rdy  input  1  command strobe, sampled high for one cycle.
REQ-010 i_u  input  I_U_NUM_BITS  user id: the login subject for Login, or the target user for AddUsr and DelUsr.
REQ-011 i_a  input  I_A_NUM_ASCII_CHARS*8  ASCII command, right-justified and zero-padded.
REQ-012 i_item  input  I_ITEM_NUM_BITS  item index.
REQ-013 i_qty  input  QTY_BITS  quantity.
REQ-014 o_a  output  O_A_NUM_ASCII_CHARS*8  ASCII response, right-justified and zero-padded.
REQ-015 o_valid  output  1  one-cycle pulse marking a new o_a value.
REQ-016 o_busy  output  1  high while a command is in flight.

Function
REQ-017 Command keys SHALL be "Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem" and "Buy"; any other i_a value SHALL decode as BAD_CMD.
REQ-018 The FSM SHALL have states IDLE -> DECODE -> EXEC -> RESP -> IDLE, with one cycle per state.
REQ-019 In IDLE, i_rdy=1 SHALL capture i_u, i_a, i_item and i_qty, set o_busy=1 and move to DECODE.
REQ-020 i_rdy while o_busy=1 SHALL be ignored, with no queuing.
REQ-021 o_valid SHALL pulse exactly 3 cycles after the i_rdy sample edge, in RESP; o_a SHALL be updated on the same edge and held until the next response.
REQ-022 The block SHALL keep a session register: either none or the logged-in user id.
REQ-023 Actor SHALL mean the session user.
REQ-024 Login SHALL return "BAD_USER" if i_u >= MAX_USERS or the slot is not present, "DENIED" if a session already exists, and otherwise set session=i_u and return "OK".
REQ-025 Logout SHALL return "DENIED" if there is no session, and otherwise clear the session and return "OK".
REQ-026 AddUsr and DelUsr SHALL return "DENIED" unless actor=0; they SHALL return "BAD_USER" if i_u >= MAX_USERS or i_u=0.
REQ-027 AddUsr SHALL set the slot present and return "OK", including when the slot is already present (idempotent).
REQ-028 DelUsr SHALL clear the slot present and return "OK" if it was present, otherwise "BAD_USER".
REQ-029 AddItem SHALL require actor=0, else "DENIED", and i_item < MAX_ITEMS, else "BAD_ITEM".
REQ-030 AddItem SHALL set stock = stock + i_qty, saturating at 2^QTY_BITS-1, and return "OK".
REQ-031 DelItem SHALL apply the same checks as AddItem, set stock=0 and return "OK".
REQ-032 Buy SHALL return "DENIED" if there is no session and "BAD_ITEM" if i_item >= MAX_ITEMS.
REQ-033 Buy SHALL return "NO_STOCK" if i_qty > stock or i_qty=0, leaving stock unchanged.
REQ-034 Otherwise Buy SHALL set stock = stock - i_qty and return "OK".
REQ-035 BAD_CMD SHALL return "BAD_CMD" and change no state.
REQ-036 Check priority SHALL be command, then permission, then index, then stock.
REQ-037 Only the EXEC cycle SHALL write the tables; at most one entry SHALL be written per command.

Reset
REQ-038 Asserting i_reset_n=0 SHALL immediately force:
- FSM=IDLE, o_busy=0, o_valid=0;
- o_a="NONE";
- session=none;
- only slot 0 present;
- all stock=0.
REQ-039 A reset during DECODE, EXEC or RESP SHALL abort the command with no table write and no o_valid.

Structure
REQ-040 The command key strings, response strings and a 3-bit opcode encoding SHALL live in the shared include shop_pkg.vh.
REQ-041 ASCII-to-opcode decode SHALL be the sub-module shop_cmd_decode_v, purely combinational, instantiated once.
REQ-042 The user table SHALL be a MAX_USERS-bit register and the stock table a MAX_ITEMS x QTY_BITS register array, both held in shop_db_v.

Verification
REQ-043 Reset, then Login with i_u=1 -> "BAD_USER"; then Login with i_u=0 -> "OK", o_valid exactly 3 cycles after i_rdy.
REQ-044 As admin, AddUsr i_u=2 -> "OK"; AddItem item=3 qty=200 -> "OK"; AddItem item=3 qty=100 -> "OK", stock[3]=255 (saturated).
REQ-045 Logout -> "OK"; Login i_u=2 -> "OK"; Buy item=3 qty=10 -> "OK", stock[3]=245; Buy qty=250 -> "NO_STOCK"; AddItem -> "DENIED"; i_a="hi" -> "BAD_CMD".
REQ-046 A second i_rdy pulse one cycle after the first -> exactly one o_valid.
REQ-047 i_reset_n low during EXEC -> o_valid stays 0, o_a="NONE", session cleared, stock[3] unchanged from its pre-command value.
REQ-048 As admin, DelUsr i_u=0 -> "BAD_USER"; Buy item=MAX_ITEMS -> "BAD_ITEM"; Login while logged in -> "DENIED".

Source files
------------

// File: rtl/shop_pkg.sv
// Shared definitions for the shop database: command keys, response strings,
// the 3-bit opcode encoding and the FSM state encoding.
package shop_pkg;

  // Strings are kept at a common width and trimmed/extended at the ports.
  localparam int STR_W = 128;

  typedef enum logic [2:0] {
    OP_LOGOUT  = 3'd0,
    OP_LOGIN   = 3'd1,
    OP_ADDUSR  = 3'd2,
    OP_DELUSR  = 3'd3,
    OP_ADDITEM = 3'd4,
    OP_DELITEM = 3'd5,
    OP_BUY     = 3'd6,
    OP_BAD     = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Command keys, right-justified and zero-padded.
  localparam logic [STR_W-1:0] KEY_LOGOUT  = {80'd0, "Logout"};
  localparam logic [STR_W-1:0] KEY_LOGIN   = {88'd0, "Login"};
  localparam logic [STR_W-1:0] KEY_ADDUSR  = {80'd0, "AddUsr"};
  localparam logic [STR_W-1:0] KEY_DELUSR  = {80'd0, "DelUsr"};
  localparam logic [STR_W-1:0] KEY_ADDITEM = {72'd0, "AddItem"};
  localparam logic [STR_W-1:0] KEY_DELITEM = {72'd0, "DelItem"};
  localparam logic [STR_W-1:0] KEY_BUY     = {104'd0, "Buy"};

  // Response strings, right-justified and zero-padded.
  localparam logic [STR_W-1:0] RSP_OK       = {112'd0, "OK"};
  localparam logic [STR_W-1:0] RSP_DENIED   = {80'd0, "DENIED"};
  localparam logic [STR_W-1:0] RSP_BAD_USER = {64'd0, "BAD_USER"};
  localparam logic [STR_W-1:0] RSP_BAD_ITEM = {64'd0, "BAD_ITEM"};
  localparam logic [STR_W-1:0] RSP_NO_STOCK = {64'd0, "NO_STOCK"};
  localparam logic [STR_W-1:0] RSP_BAD_CMD  = {72'd0, "BAD_CMD"};
  localparam logic [STR_W-1:0] RSP_NONE     = {96'd0, "NONE"};

endpackage

// File: rtl/shop_cmd_decode_v.sv
// Combinational ASCII command to opcode decoder. Anything that is not an
// exact key match decodes as OP_BAD.
module shop_cmd_decode_v
  import shop_pkg::*;
#(
  parameter int A_CHARS = 7
) (
  input  logic [A_CHARS*8-1:0] a,
  output opcode_t              op
);

  logic [STR_W-1:0] a_ext;

  // Zero-extend the command to the common string width and match keys.
  always_comb begin
    a_ext = STR_W'(a);
    op    = OP_BAD;
    case (a_ext)
      KEY_LOGOUT:  op = OP_LOGOUT;
      KEY_LOGIN:   op = OP_LOGIN;
      KEY_ADDUSR:  op = OP_ADDUSR;
      KEY_DELUSR:  op = OP_DELUSR;
      KEY_ADDITEM: op = OP_ADDITEM;
      KEY_DELITEM: op = OP_DELITEM;
      KEY_BUY:     op = OP_BUY;
      default:     op = OP_BAD;
    endcase
  end

endmodule

// File: rtl/shop_db_v.sv
// Shop database: user table, stock table and a login session, driven by
// ASCII commands through a fixed IDLE->DECODE->EXEC->RESP sequence.
//
// Handshake: a command is accepted only when i_rdy is high on a rising edge
// while the FSM is IDLE (o_busy=0); i_rdy while busy is dropped, never
// queued. The answer appears on o_a together with a one-cycle o_valid pulse
// during RESP, three cycles after the accepting edge, and o_a holds until the
// next answer. Tables are written only on the edge that leaves EXEC.
module shop_db_v
  import shop_pkg::*;
#(
  parameter int MAX_USERS           = 5,
  parameter int MAX_ITEMS           = 8,
  parameter int QTY_BITS            = 8,
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4,
  parameter int I_ITEM_NUM_BITS     = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_rdy,
  input  logic [I_U_NUM_BITS-1:0]          i_u,
  input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a,
  input  logic [I_ITEM_NUM_BITS-1:0]       i_item,
  input  logic [QTY_BITS-1:0]              i_qty,
  output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a,
  output logic                             o_valid,
  output logic                             o_busy,
  output logic [1:0]                       o_dbg_state
);

  localparam int AW = I_A_NUM_ASCII_CHARS * 8;
  localparam int OW = O_A_NUM_ASCII_CHARS * 8;

  state_t state_q, state_n;

  // Captured command
  logic [I_U_NUM_BITS-1:0]    u_q;
  logic [AW-1:0]              a_q;
  logic [I_ITEM_NUM_BITS-1:0] item_q;
  logic [QTY_BITS-1:0]        qty_q;
  opcode_t                    op_dec, op_q;

  // Tables and session
  logic [MAX_USERS-1:0]       user_tbl;
  logic [QTY_BITS-1:0]        stock [MAX_ITEMS];
  logic                       sess_valid;
  logic [I_U_NUM_BITS-1:0]    sess_id;

  // Execute-stage results
  logic                       user_rd;
  logic [QTY_BITS-1:0]        stock_rd;
  logic [QTY_BITS:0]          stock_sum;
  logic                       u_in_range;
  logic                       item_in_range;
  logic                       actor_admin;
  logic                       user_we;
  logic                       user_wval;
  logic                       stock_we;
  logic [QTY_BITS-1:0]        stock_wval;
  logic                       sess_we;
  logic                       sess_valid_n;
  logic [OW-1:0]              resp_n;
  logic                       exec_en;

  shop_cmd_decode_v #(
    .A_CHARS(I_A_NUM_ASCII_CHARS)
  ) u_decode (
    .a  (a_q),
    .op (op_dec)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_valid     = (state_q == ST_RESP);
  assign o_dbg_state = state_q;
  assign exec_en     = (state_q == ST_EXEC);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_n;
  end

  // FSM next state: one cycle per stage, IDLE waits for i_rdy
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (i_rdy) state_n = ST_DECODE;
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC:   state_n = ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Capture the command in IDLE and latch the decoded opcode in DECODE
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      u_q    <= '0;
      a_q    <= '0;
      item_q <= '0;
      qty_q  <= '0;
      op_q   <= OP_BAD;
    end else begin
      if (state_q == ST_IDLE && i_rdy) begin
        u_q    <= i_u;
        a_q    <= i_a;
        item_q <= i_item;
        qty_q  <= i_qty;
      end
      if (state_q == ST_DECODE) op_q <= op_dec;
    end
  end

  // Table reads addressed by the captured user id and item index
  always_comb begin
    user_rd  = 1'b0;
    stock_rd = '0;
    for (int k = 0; k < MAX_USERS; k++)
      if (int'(u_q) == k) user_rd = user_tbl[k];
    for (int k = 0; k < MAX_ITEMS; k++)
      if (int'(item_q) == k) stock_rd = stock[k];
  end

  assign u_in_range    = (int'(u_q) < MAX_USERS);
  assign item_in_range = (int'(item_q) < MAX_ITEMS);
  assign actor_admin   = sess_valid && (sess_id == '0);
  assign stock_sum     = {1'b0, stock_rd} + {1'b0, qty_q};

  // Command execution: checks in order command, permission, index, stock
  always_comb begin
    user_we      = 1'b0;
    user_wval    = 1'b0;
    stock_we     = 1'b0;
    stock_wval   = '0;
    sess_we      = 1'b0;
    sess_valid_n = sess_valid;
    resp_n       = OW'(RSP_OK);
    case (op_q)
      OP_LOGIN: begin
        if (!u_in_range || !user_rd) resp_n = OW'(RSP_BAD_USER);
        else if (sess_valid)         resp_n = OW'(RSP_DENIED);
        else begin
          sess_we      = 1'b1;
          sess_valid_n = 1'b1;
        end
      end
      OP_LOGOUT: begin
        if (!sess_valid) resp_n = OW'(RSP_DENIED);
        else begin
          sess_we      = 1'b1;
          sess_valid_n = 1'b0;
        end
      end
      OP_ADDUSR, OP_DELUSR: begin
        if (!actor_admin)                     resp_n = OW'(RSP_DENIED);
        else if (!u_in_range || u_q == '0)    resp_n = OW'(RSP_BAD_USER);
        else if (op_q == OP_ADDUSR) begin
          user_we   = 1'b1;
          user_wval = 1'b1;
        end else if (!user_rd)                resp_n = OW'(RSP_BAD_USER);
        else begin
          user_we   = 1'b1;
          user_wval = 1'b0;
        end
      end
      OP_ADDITEM, OP_DELITEM: begin
        if (!actor_admin)        resp_n = OW'(RSP_DENIED);
        else if (!item_in_range) resp_n = OW'(RSP_BAD_ITEM);
        else begin
          stock_we = 1'b1;
          if (op_q == OP_DELITEM)        stock_wval = '0;
          else if (stock_sum[QTY_BITS])  stock_wval = '1;
          else                           stock_wval = stock_sum[QTY_BITS-1:0];
        end
      end
      OP_BUY: begin
        if (!sess_valid)                          resp_n = OW'(RSP_DENIED);
        else if (!item_in_range)                  resp_n = OW'(RSP_BAD_ITEM);
        else if (qty_q == '0 || qty_q > stock_rd) resp_n = OW'(RSP_NO_STOCK);
        else begin
          stock_we   = 1'b1;
          stock_wval = stock_rd - qty_q;
        end
      end
      default: resp_n = OW'(RSP_BAD_CMD);
    endcase
  end

  // Table, session and response registers, written only on the EXEC edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      user_tbl   <= {{(MAX_USERS-1){1'b0}}, 1'b1};
      for (int k = 0; k < MAX_ITEMS; k++) stock[k] <= '0;
      sess_valid <= 1'b0;
      sess_id    <= '0;
      o_a        <= OW'(RSP_NONE);
    end else if (exec_en) begin
      for (int k = 0; k < MAX_USERS; k++)
        if (user_we && int'(u_q) == k) user_tbl[k] <= user_wval;
      for (int k = 0; k < MAX_ITEMS; k++)
        if (stock_we && int'(item_q) == k) stock[k] <= stock_wval;
      if (sess_we) begin
        sess_valid <= sess_valid_n;
        sess_id    <= u_q;
      end
      o_a <= resp_n;
    end
  end

endmodule
